mult_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one repeated-addition multiplier datapath between NREQ requesters.
- Arbitrates pending requests and sequences the datapath control strobes (load A, load B, clear P, accumulate, decrement B).
- Returns the product with a per-requester done pulse.
- Sits between the requesting blocks and a single MUL_datapath-style instance; it replaces the fixed single-user controller.

---
 rtl/mult_rr_scheduler_if.sv | 33 +++
 rtl/mult_rr_scheduler.sv | 104 ++++++++++
 tb/tb_mult_rr_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_rr_scheduler_if.sv
// rtl/mult_rr_scheduler_if.sv - requester and datapath signal bundle for mult_rr_scheduler
interface mult_rr_scheduler_if #(
  parameter int NREQ = 4,
  parameter int W    = 16
);
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [W-1:0]      result;
  logic              busy;
  logic [W-1:0]      dp_data;
  logic              dp_ldA;
  logic              dp_ldB;
  logic              dp_clrP;
  logic              dp_ldP;
  logic              dp_decB;
  logic              dp_eqz;
  logic [W-1:0]      dp_prod;

  modport slave (
    input  req, a_in, b_in, dp_eqz, dp_prod,
    output gnt, done, result, busy,
    output dp_data, dp_ldA, dp_ldB, dp_clrP, dp_ldP, dp_decB
  );

  modport master (
    output req, a_in, b_in, dp_eqz, dp_prod,
    input  gnt, done, result, busy,
    input  dp_data, dp_ldA, dp_ldB, dp_clrP, dp_ldP, dp_decB
  );
endinterface

// File: rtl/mult_rr_scheduler.sv
// rtl/mult_rr_scheduler.sv - round-robin sharing of one repeated-addition multiplier datapath
module mult_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  mult_rr_scheduler_if.slave  bus
);
  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_ACC, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [SW-1:0]   r_sel;
  logic [SW-1:0]   r_last;
  logic [SW-1:0]   w_pick;
  logic            w_any;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic [W-1:0]    r_result;

  // First set request after the last winner; the smallest offset wins.
  function automatic logic [SW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                            input logic [SW-1:0]   last);
    logic [SW-1:0] pick;
    pick = last;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % NREQ]) pick = SW'((int'(last) + k) % NREQ);
    end
    return pick;
  endfunction

  assign w_any  = |bus.req;
  assign w_pick = rr_pick(bus.req, r_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    bus.dp_data = '0;
    bus.dp_ldA  = 1'b0;
    bus.dp_ldB  = 1'b0;
    bus.dp_clrP = 1'b0;
    bus.dp_ldP  = 1'b0;
    bus.dp_decB = 1'b0;
    case (r_state)
      S_IDLE: if (w_any) w_next = S_LOAD_A;
      S_LOAD_A: begin
        bus.dp_data = bus.a_in[r_sel*W +: W];
        bus.dp_ldA  = 1'b1;
        w_next      = S_LOAD_B;
      end
      S_LOAD_B: begin
        bus.dp_data = bus.b_in[r_sel*W +: W];
        bus.dp_ldB  = 1'b1;
        bus.dp_clrP = 1'b1;
        w_next      = S_ACC;
      end
      S_ACC: begin
        bus.dp_ldP  = !bus.dp_eqz;
        bus.dp_decB = !bus.dp_eqz;
        if (bus.dp_eqz) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Grant, pointer, result and done pulse all change only on state-machine edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel    <= '0;
      r_last   <= SW'(NREQ - 1);
      r_gnt    <= '0;
      r_done   <= '0;
      r_result <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: if (w_any) begin
          r_sel  <= w_pick;
          r_last <= w_pick;
          r_gnt  <= {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
        end
        S_ACC: if (bus.dp_eqz) begin
          r_result <= bus.dp_prod;
          r_done   <= {{(NREQ-1){1'b0}}, 1'b1} << r_sel;
        end
        S_DONE:  r_gnt <= '0;
        default: ;
      endcase
    end
  end

  assign bus.gnt    = r_gnt;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.busy   = (r_state != S_IDLE);
endmodule

// File: tb/tb_mult_rr_scheduler.sv
// tb/tb_mult_rr_scheduler.sv - randomized and directed bench for mult_rr_scheduler
module tb_mult_rr_scheduler;
  localparam int NREQ = 4;
  localparam int W    = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   exp_last = NREQ - 1;

  logic [W-1:0] dp_a = '0;
  logic [W-1:0] dp_b = '0;
  logic [W-1:0] dp_p = '0;

  mult_rr_scheduler_if #(.NREQ(NREQ), .W(W)) bus ();

  mult_rr_scheduler #(.NREQ(NREQ), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural repeated-addition datapath.
  always @(posedge clk) begin
    if (bus.dp_ldA) dp_a <= bus.dp_data;
    if (bus.dp_ldB) dp_b <= bus.dp_data;
    else if (bus.dp_decB) dp_b <= dp_b - 1'b1;
    if (bus.dp_clrP) dp_p <= '0;
    else if (bus.dp_ldP) dp_p <= dp_p + dp_a;
  end
  assign bus.dp_eqz  = (dp_b == '0);
  assign bus.dp_prod = dp_p;

  always @(negedge clk) begin
    checks++;
    if ($countones(bus.gnt) > 1) begin
      errors++;
      $display("FAIL gnt_onehot: gnt=%b, required at most one bit", bus.gnt);
    end
    checks++;
    if ((bus.done & ~bus.gnt) != '0) begin
      errors++;
      $display("FAIL done_without_gnt: done=%b gnt=%b, required done within gnt", bus.done, bus.gnt);
    end
  end

  function automatic int model_pick(input logic [NREQ-1:0] mask, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (mask[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic set_ops(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.a_in[idx*W +: W] = a;
    bus.b_in[idx*W +: W] = b;
  endtask

  task automatic do_reset();
    bus.req = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_last = NREQ - 1;
    @(negedge clk);
  endtask

  // Called at an IDLE negedge with req already set; checks one whole service.
  task automatic run_service(input int drop_at, output int got_idx);
    int exp_idx, k, cyc, nldp;
    logic [W-1:0] a, b, exp_res;
    logic [2*W-1:0] full;
    logic [NREQ-1:0] exp_gnt;
    exp_idx = model_pick(bus.req, exp_last);
    got_idx = -1;
    if (exp_idx < 0) begin
      errors++;
      $display("FAIL service_setup: no request pending, required one");
      return;
    end
    a = bus.a_in[exp_idx*W +: W];
    b = bus.b_in[exp_idx*W +: W];
    full = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    exp_res = full[W-1:0];
    exp_gnt = '0;
    exp_gnt[exp_idx] = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.gnt == '0 && k < 20);
    checks++;
    if (k != 1) begin
      errors++;
      $display("FAIL grant_latency: %0d cycles, required 1", k);
      if (bus.gnt == '0) return;
    end
    got_idx = onehot_idx(bus.gnt);
    checks++;
    if (bus.gnt !== exp_gnt) begin
      errors++;
      $display("FAIL gnt: gnt=%b, required %b", bus.gnt, exp_gnt);
    end
    exp_last = exp_idx;
    cyc = 1;
    nldp = 0;
    while (bus.done == '0 && cyc < int'(b) + 40) begin
      if (bus.dp_ldP) nldp++;
      if (cyc == drop_at) bus.req[exp_idx] = 1'b0;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != int'(b) + 4) begin
      errors++;
      $display("FAIL done_cycle: cycle %0d, required %0d", cyc, int'(b) + 4);
    end
    checks++;
    if (bus.done !== exp_gnt) begin
      errors++;
      $display("FAIL done: done=%b, required %b", bus.done, exp_gnt);
    end
    checks++;
    if (bus.result !== exp_res) begin
      errors++;
      $display("FAIL result: result=%h, required %h (A=%h B=%h)", bus.result, exp_res, a, b);
    end
    checks++;
    if (nldp != int'(b)) begin
      errors++;
      $display("FAIL acc_count: %0d accumulates, required %0d", nldp, int'(b));
    end
    checks++;
    if (bus.gnt !== exp_gnt) begin
      errors++;
      $display("FAIL gnt_hold: gnt=%b, required %b", bus.gnt, exp_gnt);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.gnt !== '0 || bus.done !== '0) begin
      errors++;
      $display("FAIL after_done: busy=%b gnt=%b done=%b, required 0/0/0", bus.busy, bus.gnt, bus.done);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.gnt !== '0 || bus.done !== '0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: gnt=%b done=%b busy=%b, required all 0", bus.gnt, bus.done, bus.busy);
    end
    checks++;
    if (bus.result !== '0 || bus.dp_data !== '0) begin
      errors++;
      $display("FAIL reset_data: result=%h dp_data=%h, required 0", bus.result, bus.dp_data);
    end
    checks++;
    if ({bus.dp_ldA, bus.dp_ldB, bus.dp_clrP, bus.dp_ldP, bus.dp_decB} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes: %b, required 00000",
               {bus.dp_ldA, bus.dp_ldB, bus.dp_clrP, bus.dp_ldP, bus.dp_decB});
    end
  endtask

  task automatic test_single();
    int got;
    set_ops(0, 16'd7, 16'd5);
    bus.req = 4'b0001;
    run_service(-1, got);
    checks++;
    if (bus.result !== 16'd35) begin
      errors++;
      $display("FAIL single_result: result=%0d, required 35", bus.result);
    end
    bus.req = '0;
  endtask

  task automatic test_zero_b();
    int got;
    set_ops(2, 16'd9, 16'd0);
    bus.req = 4'b0100;
    run_service(-1, got);
    bus.req = '0;
  endtask

  task automatic test_back_to_back();
    int got;
    int order[4] = '{0, 3, 0, 3};
    do_reset();
    set_ops(0, 16'd3, 16'd2);
    set_ops(3, 16'd3, 16'd2);
    bus.req = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      run_service(-1, got);
      checks++;
      if (got != order[i]) begin
        errors++;
        $display("FAIL rr_order: service %0d went to %0d, required %0d", i, got, order[i]);
      end
    end
    bus.req = '0;
  endtask

  task automatic test_wrap();
    int got;
    set_ops(1, 16'hFFFF, 16'd2);
    bus.req = 4'b0010;
    run_service(-1, got);
    checks++;
    if (bus.result !== 16'hFFFE) begin
      errors++;
      $display("FAIL wrap_result: result=%h, required fffe", bus.result);
    end
    bus.req = '0;
  endtask

  task automatic test_reset_mid();
    int got, k;
    set_ops(1, 16'd11, 16'd6);
    bus.req = 4'b0010;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.gnt == '0 && k < 20);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.gnt !== 4'b0010) begin
      errors++;
      $display("FAIL mid_busy: busy=%b gnt=%b, required 1/0010", bus.busy, bus.gnt);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.gnt !== '0 || bus.done !== '0 || bus.busy !== 1'b0 || bus.result !== '0) begin
      errors++;
      $display("FAIL async_reset: gnt=%b done=%b busy=%b result=%h, required all 0",
               bus.gnt, bus.done, bus.busy, bus.result);
    end
    checks++;
    if ({bus.dp_ldP, bus.dp_decB, bus.dp_ldA, bus.dp_ldB, bus.dp_clrP} !== 5'b0 || bus.dp_data !== '0) begin
      errors++;
      $display("FAIL async_reset_dp: strobes=%b dp_data=%h, required 0",
               {bus.dp_ldP, bus.dp_decB, bus.dp_ldA, bus.dp_ldB, bus.dp_clrP}, bus.dp_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_last = NREQ - 1;
    run_service(-1, got);
    bus.req = '0;
  endtask

  task automatic test_drop_req();
    int got;
    set_ops(2, 16'd5, 16'd4);
    bus.req = 4'b0100;
    run_service(2, got);
    checks++;
    if (bus.result !== 16'd20) begin
      errors++;
      $display("FAIL drop_result: result=%0d, required 20", bus.result);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.gnt !== '0) begin
        errors++;
        $display("FAIL drop_regrant: gnt=%b, required 0000", bus.gnt);
      end
    end
  endtask

  task automatic test_random();
    int got;
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < NREQ; i++)
        set_ops(i, W'($urandom), W'($urandom_range(0, 7)));
      bus.req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      run_service(-1, got);
    end
    bus.req = '0;
  endtask

  initial begin
    bus.req  = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    test_reset();
    test_single();
    test_zero_b();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_drop_req();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
